// File: rtl/lsq_pkg.sv
// Shared defines (ADDR_WIDTH, FSM encodings) and the lsq package.
// LSQ_FLUSH_EN is left undefined by default; define it to add the flush port.
`ifndef LSQ_DEFINES_SVH
`define LSQ_DEFINES_SVH
`define ADDR_WIDTH 32
`define LSQ_IDLE   2'd0
`define LSQ_ISSUE  2'd1
`define LSQ_WAIT   2'd2
`define LSQ_POP    2'd3
`endif

package lsq_pkg;
    localparam int LSQ_ADDR_WIDTH = `ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = `LSQ_IDLE,
        ST_ISSUE = `LSQ_ISSUE,
        ST_WAIT  = `LSQ_WAIT,
        ST_POP   = `LSQ_POP
    } lsq_state_e;
endpackage

// File: rtl/lsq_tag_match.sv
// DEPTH-way PC comparator: one-hot hit vector over the valid entries for AGU fills.
module lsq_tag_match
    import lsq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PC_WIDTH = 32
) (
    input  logic [DEPTH-1:0]               valid,
    input  logic [DEPTH-1:0][PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0]            key,
    output logic [DEPTH-1:0]               hit
);
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign hit[gi] = valid[gi] && (pc[gi] == key);
    end
endmodule

// File: rtl/lsq.sv
// In-order load/store queue feeding the LSU; issues the head, waits for lsu_done, pops.
// Optional flush port and killed-entry handling are enabled with LSQ_FLUSH_EN.
module lsq
    import lsq_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = LSQ_ADDR_WIDTH,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic                  alloc_ls,
    input  logic [PC_WIDTH-1:0]   alloc_pc,
    output logic                  alloc_ready,
    input  logic                  agu_valid,
    input  logic [PC_WIDTH-1:0]   agu_pc,
    input  logic [ADDR_WIDTH-1:0] agu_addr,
    input  logic [31:0]           agu_data,
    input  logic                  store_commit,
    output logic                  lsu_en,
    output logic                  lsu_ls,
    output logic [ADDR_WIDTH-1:0] lsu_addr,
    output logic [31:0]           lsu_data,
    output logic [PC_WIDTH-1:0]   lsu_pc,
    input  logic                  lsu_done,
    input  logic [31:0]           lsu_load_data,
    output logic                  wb_valid,
    output logic [PC_WIDTH-1:0]   wb_pc,
    output logic                  wb_ls,
    output logic [31:0]           wb_data
`ifdef LSQ_FLUSH_EN
    ,
    input  logic                  flush
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [DEPTH-1:0]                 valid_q, ls_q, rdy_q;
    logic [DEPTH-1:0][PC_WIDTH-1:0]   pc_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][31:0]           data_q;
    logic [PW-1:0]                    head_q, head_d, tail_q, tail_d;
    logic [PW:0]                      count_q, count_d;
    lsq_state_e                       state_q;

    logic                  lsu_en_q, lsu_ls_q, wb_valid_q, wb_ls_q;
    logic [ADDR_WIDTH-1:0] lsu_addr_q;
    logic [31:0]           lsu_data_q, wb_data_q;
    logic [PC_WIDTH-1:0]   lsu_pc_q, wb_pc_q;

    logic [DEPTH-1:0] hit;
    logic             push, pop, head_go, flush_w, killed_head;

`ifdef LSQ_FLUSH_EN
    logic [DEPTH-1:0] killed_q;
    assign flush_w     = flush;
    assign killed_head = killed_q[head_q];
`else
    assign flush_w     = 1'b0;
    assign killed_head = 1'b0;
`endif

    lsq_tag_match #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) u_match (
        .valid (valid_q),
        .pc    (pc_q),
        .key   (agu_pc),
        .hit   (hit)
    );

    assign alloc_ready = (count_q != FULL);
    assign push        = alloc_valid && alloc_ready && !flush_w;
    assign pop         = (state_q == ST_POP);
    assign head_go     = (state_q == ST_IDLE) && valid_q[head_q] && rdy_q[head_q]
                         && (ls_q[head_q] || store_commit) && !flush_w;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_w) begin
            case (state_q)
                ST_IDLE: begin
                    tail_d  = head_q;
                    count_d = '0;
                end
                ST_POP: begin
                    head_d  = head_q + PW'(1);
                    tail_d  = head_q + PW'(1);
                    count_d = '0;
                end
                // ISSUE/WAIT: the in-flight head survives, marked killed
                default: begin
                    tail_d  = head_q + PW'(1);
                    count_d = (PW+1)'(1);
                end
            endcase
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ls_q    <= '0;
            rdy_q   <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (agu_valid && hit[i] && !flush_w) begin
                    addr_q[i] <= agu_addr;
                    data_q[i] <= agu_data;
                    rdy_q[i]  <= 1'b1;
                end
            end
            // Alloc targets an invalid slot, so a same-cycle fill can never hit it
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                ls_q[tail_q]    <= alloc_ls;
                pc_q[tail_q]    <= alloc_pc;
                rdy_q[tail_q]   <= 1'b0;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                rdy_q[head_q]   <= 1'b0;
            end
`ifdef LSQ_FLUSH_EN
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (state_q == ST_IDLE || state_q == ST_POP || PW'(i) != head_q) begin
                        valid_q[i] <= 1'b0;
                        rdy_q[i]   <= 1'b0;
                    end
                end
            end
`endif
        end
    end

`ifdef LSQ_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            killed_q <= '0;
        end else begin
            if (push) killed_q[tail_q] <= 1'b0;
            if (pop)  killed_q[head_q] <= 1'b0;
            if (flush && (state_q == ST_ISSUE || state_q == ST_WAIT))
                killed_q[head_q] <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lsu_en_q   <= 1'b0;
            lsu_ls_q   <= 1'b0;
            lsu_addr_q <= '0;
            lsu_data_q <= '0;
            lsu_pc_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_ls_q    <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            lsu_en_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (head_go) begin
                        state_q    <= ST_ISSUE;
                        lsu_en_q   <= 1'b1;
                        lsu_ls_q   <= ls_q[head_q];
                        lsu_addr_q <= addr_q[head_q];
                        lsu_data_q <= data_q[head_q];
                        lsu_pc_q   <= pc_q[head_q];
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (lsu_done) begin
                        state_q    <= ST_POP;
                        wb_valid_q <= !(killed_head || flush_w);
                        wb_pc_q    <= pc_q[head_q];
                        wb_ls_q    <= ls_q[head_q];
                        wb_data_q  <= ls_q[head_q] ? lsu_load_data : 32'h0;
                    end
                end
                ST_POP:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign lsu_en   = lsu_en_q;
    assign lsu_ls   = lsu_ls_q;
    assign lsu_addr = lsu_addr_q;
    assign lsu_data = lsu_data_q;
    assign lsu_pc   = lsu_pc_q;
    assign wb_valid = wb_valid_q;
    assign wb_pc    = wb_pc_q;
    assign wb_ls    = wb_ls_q;
    assign wb_data  = wb_data_q;
endmodule

// File: tb/tb_lsq.sv
// Scoreboard bench for lsq: program-order issue/writeback model with an LSU responder.
module tb_lsq;
    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int PCW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           alloc_valid = 1'b0, alloc_ls = 1'b0;
    logic [PCW-1:0] alloc_pc = '0;
    logic           alloc_ready;
    logic           agu_valid = 1'b0;
    logic [PCW-1:0] agu_pc = '0;
    logic [AW-1:0]  agu_addr = '0;
    logic [31:0]    agu_data = '0;
    logic           store_commit = 1'b0;
    logic           lsu_en, lsu_ls;
    logic [AW-1:0]  lsu_addr;
    logic [31:0]    lsu_data;
    logic [PCW-1:0] lsu_pc;
    logic           lsu_done = 1'b0;
    logic [31:0]    lsu_load_data = '0;
    logic           wb_valid, wb_ls;
    logic [PCW-1:0] wb_pc;
    logic [31:0]    wb_data;
`ifdef LSQ_FLUSH_EN
    logic           flush = 1'b0;
`endif

    lsq #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .PC_WIDTH(PCW)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ls(alloc_ls), .alloc_pc(alloc_pc), .alloc_ready(alloc_ready),
        .agu_valid(agu_valid), .agu_pc(agu_pc), .agu_addr(agu_addr), .agu_data(agu_data),
        .store_commit(store_commit),
        .lsu_en(lsu_en), .lsu_ls(lsu_ls), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_pc(lsu_pc),
        .lsu_done(lsu_done), .lsu_load_data(lsu_load_data),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ls(wb_ls), .wb_data(wb_data)
`ifdef LSQ_FLUSH_EN
        , .flush(flush)
`endif
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic        ls;
        logic [31:0] data;
    } wb_t;

    wb_t         wb_q[$];
    logic [31:0] ord_q[$];
    logic [31:0] unf_q[$];
    logic        m_ls   [256];
    logic [31:0] m_addr [256];
    logic [31:0] m_data [256];
    int          m_count = 0;
    bit          pop_pend = 0, busy = 0, auto_done = 1, fixed_ld = 0, exp_wb_next = 0;
    int          wcnt = 0, lat = 1, n_issue = 0;
    logic [31:0] cur_pc = '0, fixed_val = '0, next_pc = 32'h200;

    function automatic int ix(input logic [31:0] pc);
        return int'(pc[9:2]);
    endfunction

    function automatic logic [31:0] ld_fn(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock: update model with this cycle's stimulus, then sample 1ns after the edge
    task automatic step();
        bit  acc;
        wb_t e;
        acc = alloc_valid && (m_count != DEPTH);
        if (acc) begin
            ord_q.push_back(alloc_pc);
            unf_q.push_back(alloc_pc);
            m_ls[ix(alloc_pc)] = alloc_ls;
        end
        if (agu_valid) begin
            m_addr[ix(agu_pc)] = agu_addr;
            m_data[ix(agu_pc)] = agu_data;
            for (int i = 0; i < unf_q.size(); i++)
                if (unf_q[i] == agu_pc) begin unf_q.delete(i); break; end
        end
        @(posedge clk); #1;
        if (acc) m_count++;
        if (pop_pend) begin m_count--; pop_pend = 0; end
        lsu_done = 1'b0;
        chk("alloc_ready", alloc_ready, m_count != DEPTH);
        if (exp_wb_next) chk("wb_latency", wb_valid, 1);
        exp_wb_next = 0;
        if (wb_valid) begin
            if (wb_q.size() == 0) chk("wb_unexpected", wb_valid, 0);
            else begin
                e = wb_q.pop_front();
                chk("wb_pc", wb_pc, e.pc);
                chk("wb_ls", wb_ls, e.ls);
                chk("wb_data", wb_data, e.data);
                $display("wb pc=%0h ls=%0d data=%0h", wb_pc, wb_ls, wb_data);
            end
            pop_pend = 1;
        end
        if (lsu_en) begin
            n_issue++;
            if (ord_q.size() == 0 || busy) chk("lsu_en_unexpected", lsu_en, 0);
            else begin
                cur_pc = ord_q.pop_front();
                chk("lsu_pc", lsu_pc, cur_pc);
                chk("lsu_ls", lsu_ls, m_ls[ix(cur_pc)]);
                chk("lsu_addr", lsu_addr, m_addr[ix(cur_pc)]);
                if (!m_ls[ix(cur_pc)]) chk("lsu_data", lsu_data, m_data[ix(cur_pc)]);
                $display("issue pc=%0h ls=%0d addr=%0h", lsu_pc, lsu_ls, lsu_addr);
                busy = 1;
                wcnt = lat;
            end
        end else if (busy && auto_done) begin
            if (wcnt > 0) wcnt--;
            else begin
                chk("hold_addr", lsu_addr, m_addr[ix(cur_pc)]);
                chk("hold_pc", lsu_pc, cur_pc);
                if (!m_ls[ix(cur_pc)]) chk("hold_data", lsu_data, m_data[ix(cur_pc)]);
                lsu_done = 1'b1;
                lsu_load_data = fixed_ld ? fixed_val : ld_fn(m_addr[ix(cur_pc)]);
                e.pc = cur_pc;
                e.ls = m_ls[ix(cur_pc)];
                e.data = e.ls ? lsu_load_data : 32'h0;
                wb_q.push_back(e);
                exp_wb_next = 1;
                busy = 0;
            end
        end
    endtask

    task automatic do_alloc(input logic ls, input logic [31:0] pc);
        alloc_valid = 1'b1; alloc_ls = ls; alloc_pc = pc;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        agu_valid = 1'b1; agu_pc = pc; agu_addr = addr; agu_data = data;
        step();
        agu_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (ord_q.size() == 0 && unf_q.size() == 0 && wb_q.size() == 0 && !busy && !pop_pend) break;
            if (unf_q.size() > 0) do_fill(unf_q[0], $urandom, $urandom);
            else step();
        end
        chk("drain_timeout", k < budget, 1);
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 20 && !busy; k++) step();
        chk("busy_reached", busy, 1);
    endtask

    initial begin
        int base;
        step(); step();
        rst = 1'b0;
        chk("rst_lsu_en", lsu_en, 0);
        chk("rst_lsu_ls", lsu_ls, 0);
        chk("rst_lsu_addr", lsu_addr, 0);
        chk("rst_lsu_data", lsu_data, 0);
        chk("rst_lsu_pc", lsu_pc, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_pc", wb_pc, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_alloc_ready", alloc_ready, 1);

        // load at 0x40, addr 0x100, LSU returns DEADBEEF
        fixed_ld = 1; fixed_val = 32'hDEADBEEF;
        do_alloc(1'b1, 32'h40);
        do_fill(32'h40, 32'h100, 32'h0);
        step();
        chk("t1_lsu_en", lsu_en, 1);
        chk("t1_lsu_addr", lsu_addr, 32'h100);
        drain(40);
        fixed_ld = 0;

        // store waits for store_commit; data held through a longer WAIT
        lat = 3;
        do_alloc(1'b0, next_pc);
        do_fill(next_pc, 32'h300, 32'h12345678);
        next_pc += 4;
        base = n_issue;
        for (int k = 0; k < 5; k++) step();
        chk("store_no_commit_issue", n_issue - base, 0);
        store_commit = 1'b1;
        step();
        chk("store_lsu_en", lsu_en, 1);
        chk("store_lsu_ls", lsu_ls, 0);
        drain(40);
        lat = 1;

        // fill the queue, drop a ninth alloc, then pop one
        for (int k = 0; k < DEPTH; k++) begin
            do_alloc(1'b1, next_pc);
            next_pc += 4;
        end
        chk("full_ready", alloc_ready, 0);
        do_alloc(1'b1, next_pc);
        chk("ninth_dropped", ord_q.size(), DEPTH);
        do_fill(ord_q[0], 32'h1000, 32'h0);
        for (int k = 0; k < 20 && m_count == DEPTH; k++) step();
        chk("full_unblock", alloc_ready, 1);

        // mixed traffic with random fills; pointers wrap several times
        for (int k = 0; k < 60; k++) begin
            if (m_count != DEPTH && $urandom_range(3) != 0) begin
                alloc_valid = 1'b1; alloc_ls = 1'($urandom_range(1)); alloc_pc = next_pc;
                next_pc += 4;
            end
            if (unf_q.size() > 0 && $urandom_range(1) != 0) begin
                agu_valid = 1'b1;
                agu_pc = unf_q[$urandom_range(unf_q.size() - 1)];
                agu_addr = $urandom; agu_data = $urandom;
            end
            step();
            alloc_valid = 1'b0; agu_valid = 1'b0;
        end
        drain(200);

        // out-of-order fill: third, second, then head
        begin
            logic [31:0] pa, pb, pc3;
            pa = next_pc; pb = next_pc + 4; pc3 = next_pc + 8;
            next_pc += 12;
            do_alloc(1'b1, pa); do_alloc(1'b1, pb); do_alloc(1'b1, pc3);
            base = n_issue;
            do_fill(pc3, 32'h3300, 32'h0);
            step(); step(); step();
            chk("ooo_no_issue_3", n_issue - base, 0);
            do_fill(pb, 32'h2200, 32'h0);
            step(); step(); step();
            chk("ooo_no_issue_2", n_issue - base, 0);
            do_fill(pa, 32'h1100, 32'h0);
            drain(60);
            chk("ooo_issued", n_issue - base, 3);
        end

        // reset while the LSU is busy; a late lsu_done is ignored
        do_alloc(1'b1, next_pc);
        do_fill(next_pc, 32'h4400, 32'h0);
        next_pc += 4;
        auto_done = 0;
        wait_busy();
        step();
        rst = 1'b1;
        ord_q.delete(); unf_q.delete(); wb_q.delete();
        busy = 0; m_count = 0; pop_pend = 0;
        step();
        rst = 1'b0;
        lsu_done = 1'b1;
        step();
        base = n_issue;
        step(); step();
        chk("rst_wait_wb", wb_valid, 0);
        chk("rst_wait_lsu_en", lsu_en, 0);
        chk("rst_wait_lsu_addr", lsu_addr, 0);
        chk("rst_wait_wb_pc", wb_pc, 0);
        chk("rst_wait_noissue", n_issue - base, 0);
        auto_done = 1;

`ifdef LSQ_FLUSH_EN
        // flush in WAIT keeps only the killed head; it completes silently
        auto_done = 0;
        for (int k = 0; k < 3; k++) begin
            do_alloc(1'b1, next_pc);
            do_fill(next_pc, 32'h5000 + next_pc, 32'h0);
            next_pc += 4;
        end
        wait_busy();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        ord_q.delete(); unf_q.delete();
        m_count = 1; busy = 0;
        lsu_done = 1'b1;
        step(); step();
        chk("flush_no_wb", wb_valid, 0);
        m_count = 0;
        auto_done = 1;
        base = n_issue;
        do_alloc(1'b1, next_pc);
        do_fill(next_pc, 32'h6000, 32'h0);
        next_pc += 4;
        drain(40);
        chk("flush_then_one", n_issue - base, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
